mod_147_3_7_link_monitor: RTL

Synthesizable Clause 147.3.7 link monitor for the 10BASE-T1S PCS. It tracks receive descrambler lock and holds `link_status` at FAIL until lock has persisted for the full 50 ms link hold time. It contains a cycle-counting implementation of `link_hold_timer` and exports that timer's done/not-done pair in the same form as the simulation timer model. It sits downstream of the PCS receive descrambler and feeds `link_status` to the PHY Control and PMA Control functions.

---
 rtl/mod_147_3_7_link_monitor.sv | 112 +++++++++++
 1 files changed

// File: rtl/mod_147_3_7_link_monitor.sv
// Link monitor: holds link_status at FAIL until descrambler lock persists for LINK_HOLD_CYCLES.
// Optional LINK_MONITOR_STATS_EN adds a saturating 8-bit link drop counter.
module mod_147_3_7_link_monitor #(
  parameter int unsigned LINK_HOLD_CYCLES = 1250000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_pma_reset,
  input  logic       i_link_control,
  input  logic       i_scr_status,
  output logic       o_link_status,
  output logic       o_link_hold_timer_done,
  output logic       o_link_hold_timer_not_done,
  output logic [1:0] o_lm_state
`ifdef LINK_MONITOR_STATS_EN
  ,
  output logic [7:0] o_link_drop_count
`endif
);

  typedef enum logic [1:0] {
    StLinkDown = 2'b00,
    StLinkHold = 2'b01,
    StLinkUp   = 2'b10
  } state_e;

  localparam logic [20:0] LoadVal = 21'(LINK_HOLD_CYCLES - 1);

  state_e      r_state, w_state_d;
  logic [20:0] r_cnt, w_cnt_d;
  logic        r_link, w_link_d;
  logic        r_done, w_done_d;
  logic        r_not_done, w_not_done_d;
  // Low for the first edge after reset release so no state change happens on that edge.
  logic        r_armed;
  logic        w_force_down;

  assign w_force_down = i_pma_reset | ~i_link_control | ~r_armed;

  always_comb begin
    w_state_d = r_state;
    if (w_force_down) begin
      w_state_d = StLinkDown;
    end else begin
      unique case (r_state)
        StLinkDown: if (i_scr_status) w_state_d = StLinkHold;
        StLinkHold: begin
          if (!i_scr_status)     w_state_d = StLinkDown;
          else if (r_cnt == '0)  w_state_d = StLinkUp;
        end
        StLinkUp:   if (!i_scr_status) w_state_d = StLinkDown;
        default:    w_state_d = StLinkDown;
      endcase
    end
  end

  always_comb begin
    w_cnt_d = '0;
    if (w_state_d == StLinkHold) begin
      if (r_state != StLinkHold) w_cnt_d = LoadVal;
      else if (r_cnt != '0)      w_cnt_d = r_cnt - 21'd1;
    end
  end

  // Outputs are registered; the fall of link_status tracks the next state so loss of link
  // shows on the very next edge, while its rise waits one cycle after the done pulse.
  always_comb begin
    w_link_d     = (r_state == StLinkUp) && (w_state_d == StLinkUp);
    w_done_d     = (r_state == StLinkHold) && (r_cnt == '0) && (w_state_d == StLinkUp);
    w_not_done_d = (r_state == StLinkHold) && (r_cnt != '0) && (w_state_d == StLinkHold);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_armed    <= 1'b0;
      r_state    <= StLinkDown;
      r_cnt      <= '0;
      r_link     <= 1'b0;
      r_done     <= 1'b0;
      r_not_done <= 1'b0;
    end else begin
      r_armed    <= 1'b1;
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_link     <= w_link_d;
      r_done     <= w_done_d;
      r_not_done <= w_not_done_d;
    end
  end

  assign o_link_status              = r_link;
  assign o_link_hold_timer_done     = r_done;
  assign o_link_hold_timer_not_done = r_not_done;
  assign o_lm_state                 = r_state;

`ifdef LINK_MONITOR_STATS_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_drop_cnt <= '0;
    end else if (i_pma_reset) begin
      r_drop_cnt <= '0;
    end else if ((r_state == StLinkUp) && (w_state_d == StLinkDown) && (r_drop_cnt != 8'hff)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign o_link_drop_count = r_drop_cnt;
`endif

endmodule
